// File: rtl/prt_dptx_pkg.sv
// Shared types and symbol constants for the DP TX link-domain pattern generator.
// pat_sym() returns the symbol for one slot of a generated (non-MAIN) pattern.
package prt_dptx_pkg;

   typedef enum logic [2:0] {
      PAT_OFF  = 3'd0,
      PAT_TPS1 = 3'd1,
      PAT_TPS2 = 3'd2,
      PAT_IDLE = 3'd3,
      PAT_MAIN = 3'd4
   } pat_e;

   localparam logic [8:0] K28_5    = 9'h1BC;
   localparam logic [8:0] K28_0    = 9'h11C;
   localparam logic [8:0] D10_2    = 9'h04A;
   localparam logic [8:0] D11_6    = 9'h0CB;
   // NoVideoStream=1, VerticalBlank=1
   localparam logic [8:0] VB_ID    = 9'h009;
   localparam logic [8:0] SYM_ZERO = 9'h000;

   localparam int IDLE_LEN    = 8192;
   localparam int SR_INTERVAL = 512;
   localparam int TPS2_LEN    = 10;
   localparam int CNT_W       = $clog2(IDLE_LEN);
   localparam int BS_W        = $clog2(SR_INTERVAL);

   function automatic logic [8:0] pat_sym(input pat_e pat, input logic [CNT_W-1:0] idx,
                                          input logic sr);
      logic [8:0] sym;
      sym = SYM_ZERO;
      case (pat)
         PAT_TPS1: sym = D10_2;
         PAT_TPS2: begin
            if (idx == 13'd0 || idx == 13'd2)      sym = K28_5;
            else if (idx == 13'd1 || idx == 13'd3) sym = D11_6;
            else                                   sym = D10_2;
         end
         PAT_IDLE: begin
            if (idx == 13'd0)      sym = sr ? K28_0 : K28_5;
            else if (idx == 13'd1) sym = VB_ID;
            else                   sym = SYM_ZERO;
         end
         default: sym = SYM_ZERO;
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/prt_dptx_lnk_pat.sv
// DP TX link-domain symbol pattern generator: TPS1/TPS2, SST idle with SR insertion,
// or registered main-stream passthrough, identical on all lanes.
module prt_dptx_lnk_pat
   import prt_dptx_pkg::*;
#(
   parameter int P_LANES = 4,
   parameter int P_SPL   = 2
) (
   input  logic                       LNK_CLK_IN,
   input  logic                       LNK_RST_IN,
   input  logic [2:0]                 CFG_PAT_IN,
   input  logic [P_LANES*P_SPL*9-1:0] LNK_SRC_DAT_IN,
   output logic [P_LANES*P_SPL*9-1:0] LNK_DAT_OUT,
   output logic                       LNK_SCRM_EN_OUT,
   output logic [2:0]                 STA_PAT_OUT,
   output logic                       STA_SR_OUT
);

   localparam int W = P_LANES*P_SPL*9;

   pat_e             pat_q, pat_d, req;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_adv, idx;
   logic [BS_W-1:0]  bs_cnt_q, bs_cnt_d;
   logic [W-1:0]     dat_q, dat_d;
   logic             scrm_q, sr_q, sr_now, do_sw;
   logic [2:0]       sta_pat_q;

   always_comb begin
      req      = (CFG_PAT_IN > 3'd4) ? PAT_OFF : pat_e'(CFG_PAT_IN);
      cnt_adv  = cnt_q + CNT_W'(P_SPL);
      if (pat_q == PAT_TPS2 && cnt_adv >= CNT_W'(TPS2_LEN))
         cnt_adv = cnt_adv - CNT_W'(TPS2_LEN);
      // Leaving TPS2 only on the edge that completes a period, so it is never truncated.
      do_sw    = (req != pat_q) && ((pat_q != PAT_TPS2) || (cnt_adv == '0));
      pat_d    = do_sw ? req : pat_q;
      cnt_d    = do_sw ? '0 : cnt_adv;
      sr_now   = (pat_q == PAT_IDLE) && (cnt_q == '0) && (bs_cnt_q == '0);
      bs_cnt_d = bs_cnt_q;
      if (do_sw && (req == PAT_IDLE || req == PAT_MAIN))
         bs_cnt_d = '0;
      else if (pat_q == PAT_IDLE && cnt_q == '0)
         bs_cnt_d = bs_cnt_q + 1'b1;

      dat_d = '0;
      idx   = '0;
      if (pat_q == PAT_MAIN) begin
         dat_d = LNK_SRC_DAT_IN;
      end else begin
         for (int j = 0; j < P_SPL; j++) begin
            idx = cnt_q + CNT_W'(j);
            if (pat_q == PAT_TPS2 && idx >= CNT_W'(TPS2_LEN))
               idx = idx - CNT_W'(TPS2_LEN);
            for (int i = 0; i < P_LANES; i++)
               dat_d[(i*P_SPL+j)*9 +: 9] = pat_sym(pat_q, idx, sr_now);
         end
      end
   end

   always_ff @(posedge LNK_CLK_IN or negedge LNK_RST_IN) begin
      if (!LNK_RST_IN) begin
         pat_q     <= PAT_OFF;
         cnt_q     <= '0;
         bs_cnt_q  <= '0;
         dat_q     <= '0;
         scrm_q    <= 1'b0;
         sta_pat_q <= 3'd0;
         sr_q      <= 1'b0;
      end else begin
         pat_q     <= pat_d;
         cnt_q     <= cnt_d;
         bs_cnt_q  <= bs_cnt_d;
         dat_q     <= dat_d;
         scrm_q    <= (pat_q == PAT_IDLE) || (pat_q == PAT_MAIN);
         sta_pat_q <= pat_q;
         sr_q      <= sr_now;
      end
   end

   assign LNK_DAT_OUT     = dat_q;
   assign LNK_SCRM_EN_OUT = scrm_q;
   assign STA_PAT_OUT     = sta_pat_q;
   assign STA_SR_OUT      = sr_q;

endmodule

// File: tb/tb_prt_dptx_lnk_pat.sv
// Bench for prt_dptx_lnk_pat: a 4-lane/2-slot instance driven from a vector table and
// hand sequences, plus a 2-lane/4-slot instance for the cycle-spanning TPS2 period.
module tb_prt_dptx_lnk_pat;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  cfg2 = 3'd0, cfg4 = 3'd0;
   logic [71:0] src2 = '0, src4 = '0;
   logic [71:0] dat2, dat4;
   logic        scrm2, scrm4, sr2, sr4;
   logic [2:0]  pat2, pat4;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prt_dptx_lnk_pat #(.P_LANES(4), .P_SPL(2)) u2 (
      .LNK_CLK_IN(clk), .LNK_RST_IN(rst_n), .CFG_PAT_IN(cfg2), .LNK_SRC_DAT_IN(src2),
      .LNK_DAT_OUT(dat2), .LNK_SCRM_EN_OUT(scrm2), .STA_PAT_OUT(pat2), .STA_SR_OUT(sr2));

   prt_dptx_lnk_pat #(.P_LANES(2), .P_SPL(4)) u4 (
      .LNK_CLK_IN(clk), .LNK_RST_IN(rst_n), .CFG_PAT_IN(cfg4), .LNK_SRC_DAT_IN(src4),
      .LNK_DAT_OUT(dat4), .LNK_SCRM_EN_OUT(scrm4), .STA_PAT_OUT(pat4), .STA_SR_OUT(sr4));

   typedef struct {
      logic [2:0]  cfg;
      logic [71:0] src;
      logic [71:0] dat;
      logic [2:0]  pat;
      logic        scrm;
      logic        sr;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [71:0] r2(input logic [8:0] s0, input logic [8:0] s1);
      return {4{s1, s0}};
   endfunction

   function automatic logic [71:0] r4(input logic [8:0] s0, input logic [8:0] s1,
                                      input logic [8:0] s2, input logic [8:0] s3);
      return {2{s3, s2, s1, s0}};
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   localparam logic [71:0] SA = 72'h123456789ABCDEF012;
   localparam logic [71:0] SB = 72'hFEDCBA987654321FED;
   localparam logic [71:0] SC = 72'h0F0F0F0F0F0F0F0F0F;
   localparam logic [71:0] SD = 72'hA5A5A5A5A5A5A5A5A5;

   initial begin
      logic [71:0] ramp;
      int          sr_seen;

      vecs[0]  = '{3'd1, '0, '0,                      3'd0, 1'b0, 1'b0};
      vecs[1]  = '{3'd1, '0, r2(9'h04A, 9'h04A),      3'd1, 1'b0, 1'b0};
      vecs[2]  = '{3'd3, '0, r2(9'h04A, 9'h04A),      3'd1, 1'b0, 1'b0};
      vecs[3]  = '{3'd3, '0, r2(9'h11C, 9'h009),      3'd3, 1'b1, 1'b1};
      vecs[4]  = '{3'd3, '0, '0,                      3'd3, 1'b1, 1'b0};
      vecs[5]  = '{3'd6, '0, '0,                      3'd3, 1'b1, 1'b0};
      vecs[6]  = '{3'd6, '0, '0,                      3'd0, 1'b0, 1'b0};
      vecs[7]  = '{3'd4, SA, '0,                      3'd0, 1'b0, 1'b0};
      vecs[8]  = '{3'd4, SB, SB,                      3'd4, 1'b1, 1'b0};
      vecs[9]  = '{3'd4, SC, SC,                      3'd4, 1'b1, 1'b0};
      vecs[10] = '{3'd1, SD, SD,                      3'd4, 1'b1, 1'b0};
      vecs[11] = '{3'd1, '0, r2(9'h04A, 9'h04A),      3'd1, 1'b0, 1'b0};

      #3;
      check("reset_dat", dat2, '0);
      check("reset_pat", 72'(pat2), 72'd0);
      check("reset_scrm_sr", 72'({scrm2, sr2}), 72'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 12; k++) begin
         cfg2 = vecs[k].cfg;
         src2 = vecs[k].src;
         tick();
         check($sformatf("vec%0d_dat", k), dat2, vecs[k].dat);
         check($sformatf("vec%0d_pat", k), 72'(pat2), 72'(vecs[k].pat));
         check($sformatf("vec%0d_scrm", k), 72'(scrm2), 72'(vecs[k].scrm));
         check($sformatf("vec%0d_sr", k), 72'(sr2), 72'(vecs[k].sr));
      end

      // TPS2 with 4 slots per clock: period crosses cycle boundaries
      cfg2 = 3'd0;
      do_reset();
      cfg4 = 3'd2;
      tick();
      tick();
      check("tps2_p4_c0", dat4, r4(9'h1BC, 9'h0CB, 9'h1BC, 9'h0CB));
      check("tps2_p4_pat", 72'({scrm4, pat4}), 72'({1'b0, 3'd2}));
      tick();
      check("tps2_p4_c1", dat4, r4(9'h04A, 9'h04A, 9'h04A, 9'h04A));
      tick();
      check("tps2_p4_c2", dat4, r4(9'h04A, 9'h04A, 9'h1BC, 9'h0CB));
      cfg4 = 3'd0;

      // TPS2 -> IDLE request at s=4 waits for the period wrap
      do_reset();
      cfg2 = 3'd2;
      tick();
      tick();
      check("tps2_s0", dat2, r2(9'h1BC, 9'h0CB));
      tick();
      check("tps2_s2", dat2, r2(9'h1BC, 9'h0CB));
      cfg2 = 3'd3;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("tps2_hold%0d", k), dat2, r2(9'h04A, 9'h04A));
         check($sformatf("tps2_hold%0d_pat", k), 72'(pat2), 72'd2);
      end
      tick();
      check("idle_first_sr", dat2, r2(9'h11C, 9'h009));
      check("idle_first_flags", 72'({sr2, scrm2, pat2}), 72'({1'b1, 1'b1, 3'd3}));

      sr_seen = 0;
      for (int k = 0; k < 4095; k++) begin
         tick();
         if (sr2 !== 1'b0 || dat2 !== '0) sr_seen++;
      end
      check("idle_dummy_span", 72'(sr_seen), 72'd0);
      tick();
      check("idle_bs2", dat2, r2(9'h1BC, 9'h009));
      check("idle_bs2_sr", 72'(sr2), 72'd0);

      // Re-entering IDLE restarts the SR schedule
      cfg2 = 3'd1;
      tick();
      tick();
      cfg2 = 3'd3;
      tick();
      tick();
      check("idle_reentry_sr", dat2, r2(9'h11C, 9'h009));
      check("idle_reentry_pulse", 72'(sr2), 72'd1);

      // MAIN ramp: exactly one cycle of latency, no SR pulse
      cfg2 = 3'd4;
      tick();
      tick();
      sr_seen = 0;
      for (int k = 0; k < 6; k++) begin
         ramp = {8{9'(k * 37 + 5)}};
         src2 = ramp;
         tick();
         check($sformatf("main_ramp%0d", k), dat2, ramp);
         if (sr2 !== 1'b0) sr_seen++;
      end
      check("main_no_sr", 72'(sr_seen), 72'd0);

      // Reset in the middle of a TPS2 period
      cfg2 = 3'd0;
      do_reset();
      cfg2 = 3'd2;
      tick();
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("rst_mid_dat", dat2, '0);
      check("rst_mid_flags", 72'({sr2, scrm2, pat2}), 72'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick();
      check("rst_post_e1", dat2, '0);
      check("rst_post_e1_pat", 72'(pat2), 72'd0);
      tick();
      check("rst_post_e2", dat2, r2(9'h1BC, 9'h0CB));
      check("rst_post_e2_pat", 72'(pat2), 72'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
